// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter.
// Serialises one word per valid/ready handshake, LSB first, as
// start bit, DATA_W data bits, optional parity bit and STOP_BITS stop bits.
// The bit period (baud_div clock cycles, 0 and 1 both mean 1) is latched
// when a word is accepted, so it can change between frames but not within one.
//
// Parameters:
//   DATA_W    data bits per frame (5..9)
//   PARITY    0 none, 1 odd, 2 even
//   STOP_BITS 1 or 2
//   DIV_W     width of the baud divisor
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   baud_div   clock cycles per bit, sampled on accept
//   tx_data    word to transmit
//   tx_valid   word available
//   tx_ready   block can accept a word (IDLE only)
//   tx         serial line, idles high, registered
//   busy       high outside IDLE, registered
//   done       one-cycle pulse in the last cycle of the final stop bit
//   state_dbg  current state encoding
module uart_tx_param #(
  parameter int DATA_W    = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DIV_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx,
  output logic              busy,
  output logic              done,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  localparam logic [3:0]       LAST_DATA = 4'(DATA_W - 1);
  localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);

  state_t state_q, state_d;

  logic [DIV_W-1:0]  div_q, div_eff;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        bit_q, bit_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              accept, bit_end;

  assign tx_ready  = (state_q == S_IDLE);
  assign accept    = tx_valid & tx_ready;
  assign div_eff   = (div_q == '0) ? DIV_ONE : div_q;
  assign bit_end   = (cnt_q == div_eff - DIV_ONE);
  assign tx        = tx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state_dbg = state_q;

  // State register.
  // NOTE: sequential blocks use non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_START;
      S_START:  if (bit_end) state_d = S_DATA;
      S_DATA:   if (bit_end && bit_q == LAST_DATA)
                  state_d = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (bit_end) state_d = S_STOP;
      S_STOP:   if (bit_end && bit_q == LAST_STOP) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath next values: baud and bit counters restart on every state
  // entry; the shift register and parity are loaded only on accept.
  always_comb begin
    cnt_d   = cnt_q + DIV_ONE;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    if (state_q == S_IDLE || state_d != state_q || bit_end) cnt_d = '0;
    if (state_d != state_q)
      bit_d = '0;
    else if (bit_end && (state_q == S_DATA || state_q == S_STOP))
      bit_d = bit_q + 4'd1;
    if (accept) begin
      shreg_d = tx_data;
      par_d   = (PARITY == 1) ? ~^tx_data : ^tx_data;
    end else if (state_q == S_DATA && bit_end) begin
      shreg_d = shreg_q >> 1;
    end
  end

  // Output decode from the next state, so that the registered outputs line
  // up with the state they belong to (tx falls in the first START cycle and
  // done marks the last cycle of the final stop bit).
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_STOP) && (cnt_d == div_eff - DIV_ONE) &&
             (bit_d == LAST_STOP);
  end

  // Output registers. tx resets straight to the mark level so an aborted
  // frame never leaves a stray low on the line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      tx_q   <= tx_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q   <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
    end else begin
      if (accept) div_q <= baud_div;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
    end
  end

endmodule
